// File: rtl/protocol_pkg.sv
// rtl/protocol_pkg.sv - shared protocol widths, packet type and FIFO threshold helpers
// Contents:
//   DATA_LINE_WIDTH / CONTROL_LINE_WIDTH / PACKET_WIDTH  packet field widths
//   FIFO_DEPTH / LOG2_FIFO_DEPTH                         default FIFO geometry
//   packet_t                                             {control,data} packet
//   af_threshold / ae_threshold                          clamped flag thresholds
package protocol_pkg;

    localparam int DATA_LINE_WIDTH    = 64;
    localparam int CONTROL_LINE_WIDTH = 6;
    localparam int PACKET_WIDTH       = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
    localparam int FIFO_DEPTH         = 32;
    localparam int LOG2_FIFO_DEPTH    = 5;

    typedef logic [PACKET_WIDTH-1:0] packet_t;

    // Count at or above which almost-full is raised. A margin covering the
    // whole depth pins the flag high, so the threshold clamps to zero.
    function automatic int af_threshold(input int depth, input int margin);
        return (margin >= depth) ? 0 : depth - margin;
    endfunction

    // Count at or below which almost-empty is raised, clamped to the depth
    // so it always fits in the occupancy counter.
    function automatic int ae_threshold(input int depth, input int margin);
        return (margin >= depth) ? depth : margin;
    endfunction

endpackage

// File: rtl/packet_fifo_mem.sv
// rtl/packet_fifo_mem.sv - FIFO storage array, one sync write port and one async read port
// Ports:
//   clk        in   clock, rising edge
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write index
//   i_wr_data  in   write packet
//   i_rd_addr  in   read index
//   o_rd_data  out  combinational read of the indexed entry
module packet_fifo_mem #(
    parameter int W     = 70,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (i_wr_en) begin
            mem_d[i_wr_addr] = i_wr_data;
        end
    end

    // Storage is deliberately not reset: reset and flush only move pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/packet_fifo_v2.sv
// rtl/packet_fifo_v2.sv - parametrised synchronous packet FIFO with flags, errors, flush and FWFT
// Ports:
//   clk, rst_n                        clock (rising) and asynchronous active-low reset
//   i_write_packet_en/i_write_packet  write request and packet
//   i_read_packet_en/o_read_packet    pop request and read data
//   o_empty_flag/o_full_flag          occupancy 0 / FIFO_DEPTH
//   o_almost_empty/o_almost_full      count <= AE_MARGIN / count >= FIFO_DEPTH-AF_MARGIN
//   o_count                           occupancy 0..FIFO_DEPTH
//   i_flush                           synchronous empty, storage untouched
//   i_clear_err                       clears sticky errors (a same-cycle new error wins)
//   o_overflow/o_underflow            sticky write-while-full / read-while-empty
module packet_fifo_v2 #(
    parameter int DATA_LINE_WIDTH    = protocol_pkg::DATA_LINE_WIDTH,
    parameter int CONTROL_LINE_WIDTH = protocol_pkg::CONTROL_LINE_WIDTH,
    parameter int FIFO_DEPTH         = protocol_pkg::FIFO_DEPTH,
    parameter int LOG2_FIFO_DEPTH    = protocol_pkg::LOG2_FIFO_DEPTH,
    parameter int AF_MARGIN          = 4,
    parameter int AE_MARGIN          = 4,
    parameter int FWFT               = 0
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         i_write_packet_en,
    input  logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] i_write_packet,
    input  logic                                         i_read_packet_en,
    output logic [DATA_LINE_WIDTH+CONTROL_LINE_WIDTH-1:0] o_read_packet,
    output logic                                         o_empty_flag,
    output logic                                         o_full_flag,
    output logic                                         o_almost_empty,
    output logic                                         o_almost_full,
    output logic [LOG2_FIFO_DEPTH:0]                     o_count,
    input  logic                                         i_flush,
    input  logic                                         i_clear_err,
    output logic                                         o_overflow,
    output logic                                         o_underflow
);

    import protocol_pkg::*;

    localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;
    localparam int L = LOG2_FIFO_DEPTH;

    localparam logic [L:0] ONE_C   = (L+1)'(1);
    localparam logic [L:0] DEPTH_C = (L+1)'(FIFO_DEPTH);
    localparam logic [L:0] AF_TH_C = (L+1)'(af_threshold(FIFO_DEPTH, AF_MARGIN));
    localparam logic [L:0] AE_TH_C = (L+1)'(ae_threshold(FIFO_DEPTH, AE_MARGIN));

    logic [L:0]   wr_ptr_q, wr_ptr_d;
    logic [L:0]   rd_ptr_q, rd_ptr_d;
    logic [L:0]   count_q, count_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         ae_q, ae_d;
    logic         af_q, af_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic [W-1:0] rdata_q, rdata_d;

    logic         rd_acc;
    logic         wr_acc;
    logic         wr_err;
    logic         rd_err;
    logic         mem_we;
    logic [W-1:0] mem_rdata;

    packet_fifo_mem #(
        .W     (W),
        .DEPTH (FIFO_DEPTH),
        .AW    (L)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (mem_we),
        .i_wr_addr (wr_ptr_q[L-1:0]),
        .i_wr_data (i_write_packet),
        .i_rd_addr (rd_ptr_q[L-1:0]),
        .o_rd_data (mem_rdata)
    );

    always_comb begin
        // A pop frees a slot in the same cycle, so a write into a full FIFO
        // alongside a valid read is accepted.
        rd_acc = i_read_packet_en & ~empty_q;
        wr_acc = i_write_packet_en & (~full_q | rd_acc);
        wr_err = i_write_packet_en & full_q & ~rd_acc;
        rd_err = i_read_packet_en & empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_we   = 1'b0;
        rdata_d  = rdata_q;
        ovf_d    = ovf_q & ~i_clear_err;
        udf_d    = udf_q & ~i_clear_err;

        if (i_flush) begin
            // Flush overrides any concurrent traffic and raises no errors.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            mem_we = wr_acc;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ONE_C;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ONE_C;
            end
            count_d = count_q + (wr_acc ? ONE_C : '0) - (rd_acc ? ONE_C : '0);
            ovf_d   = ovf_d | wr_err;
            udf_d   = udf_d | rd_err;
            if (FWFT == 0 && rd_acc) begin
                rdata_d = mem_rdata;
            end
        end

        // In FWFT mode the register tracks whatever is on display so the
        // last shown packet is held once the FIFO runs empty.
        if (FWFT != 0 && !empty_q) begin
            rdata_d = mem_rdata;
        end

        // Flags come from the next count so they always agree with o_count.
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_TH_C);
        ae_d    = (count_d <= AE_TH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= (AF_TH_C == '0);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_read_packet  = (FWFT != 0 && !empty_q) ? mem_rdata : rdata_q;
    assign o_empty_flag   = empty_q;
    assign o_full_flag    = full_q;
    assign o_almost_empty = ae_q;
    assign o_almost_full  = af_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: tb/tb_packet_fifo_v2.sv
// tb/tb_packet_fifo_v2.sv - self-checking bench for packet_fifo_v2 in registered and FWFT modes
module tb_packet_fifo_v2;

    localparam int W     = 70;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         wr_en, rd_en, flush, clr;
    logic [W-1:0] wdata;

    logic [W-1:0] rp0, rp1;
    logic         e0, e1, f0, f1, ae0, ae1, af0, af1, ov0, ov1, un0, un1;
    logic [5:0]   c0, c1;

    packet_fifo_v2 #(.FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_write_packet_en(wr_en), .i_write_packet(wdata),
        .i_read_packet_en(rd_en), .o_read_packet(rp0),
        .o_empty_flag(e0), .o_full_flag(f0),
        .o_almost_empty(ae0), .o_almost_full(af0), .o_count(c0),
        .i_flush(flush), .i_clear_err(clr),
        .o_overflow(ov0), .o_underflow(un0)
    );

    packet_fifo_v2 #(.FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_write_packet_en(wr_en), .i_write_packet(wdata),
        .i_read_packet_en(rd_en), .o_read_packet(rp1),
        .o_empty_flag(e1), .o_full_flag(f1),
        .o_almost_empty(ae1), .o_almost_full(af1), .o_count(c1),
        .i_flush(flush), .i_clear_err(clr),
        .o_overflow(ov1), .o_underflow(un1)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: packet queue plus sticky flags and displayed data.
    logic [W-1:0] mq[$];
    logic         m_ovf, m_udf;
    logic [W-1:0] m_rd0, m_rd1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rd0 = '0;
        m_rd1 = '0;
    endtask

    task automatic model_step();
        int  n;
        bit  full, empty, rd_ok, wr_ok;
        n     = mq.size();
        full  = (n == DEPTH);
        empty = (n == 0);
        if (flush) begin
            mq.delete();
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            rd_ok = rd_en && !empty;
            wr_ok = wr_en && (!full || rd_ok);
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (wr_en && full && !rd_ok) m_ovf = 1'b1;
            if (rd_en && empty) m_udf = 1'b1;
            if (rd_ok) m_rd0 = mq.pop_front();
            if (wr_ok) mq.push_back(wdata);
        end
        if (mq.size() != 0) m_rd1 = mq[0];
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count0", W'(c0), W'(n));
        chk("count1", W'(c1), W'(n));
        chk("empty0", W'(e0), W'(n == 0));
        chk("empty1", W'(e1), W'(n == 0));
        chk("full0", W'(f0), W'(n == DEPTH));
        chk("full1", W'(f1), W'(n == DEPTH));
        chk("aempty0", W'(ae0), W'(n <= 4));
        chk("aempty1", W'(ae1), W'(n <= 4));
        chk("afull0", W'(af0), W'(n >= DEPTH - 4));
        chk("afull1", W'(af1), W'(n >= DEPTH - 4));
        chk("ovf0", W'(ov0), W'(m_ovf));
        chk("ovf1", W'(ov1), W'(m_ovf));
        chk("udf0", W'(un0), W'(m_udf));
        chk("udf1", W'(un1), W'(m_udf));
        chk("rdata_reg", rp0, m_rd0);
        chk("rdata_fwft", rp1, m_rd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_count"}, W'({c0, c1}), '0);
        chk({tag, "_empty"}, W'({e0, e1, ae0, ae1}), W'(4'b1111));
        chk({tag, "_full"}, W'({f0, f1, af0, af1}), '0);
        chk({tag, "_err"}, W'({ov0, ov1, un0, un1}), '0);
        chk({tag, "_rdata0"}, rp0, '0);
        chk({tag, "_rdata1"}, rp1, '0);
    endtask

    task automatic cyc(input logic w, input logic [W-1:0] d, input logic r,
                       input logic fl, input logic cl);
        wr_en = w;
        wdata = d;
        rd_en = r;
        flush = fl;
        clr   = cl;
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    initial begin
        logic [95:0]  rnd;
        logic [W-1:0] pkt;
        int           wp, rp;

        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr = 1'b0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_init");
        rst_n = 1'b1;

        // Reset asserted mid-fill discards everything.
        for (int i = 0; i < 10; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset("rst_mid");
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Fill beyond capacity.
        for (int i = 0; i < 40; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_count", W'(c0), W'(32));
        chk("fill_ovf", W'(ov0), W'(1));

        // Drain beyond empty: registered data 0..31 in order.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (i < 32) chk("drain_order", rp0, W'(i));
        end
        chk("drain_udf", W'(un0), W'(1));
        chk("drain_empty", W'(e0), W'(1));

        // Concurrent write+read while empty.
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, W'(77), 1'b1, 1'b0, 1'b0);
        chk("conc_empty_count", W'(c0), W'(1));
        chk("conc_empty_udf", W'(un0), W'(1));

        // Concurrent write+read while full.
        for (int i = 0; i < 31; i++) cyc(1'b1, W'(100 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, W'(99), 1'b1, 1'b0, 1'b0);
        chk("conc_full_count", W'(c0), W'(32));
        chk("conc_full_ovf", W'(ov0), W'(0));

        // FWFT visibility on first write.
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, W'(8'hA5), 1'b0, 1'b0, 1'b0);
        chk("fwft_empty", W'(e1), W'(0));
        chk("fwft_data", rp1, W'(8'hA5));

        // Flush after 12 entries, then error set/clear behaviour.
        for (int i = 0; i < 11; i++) cyc(1'b1, W'(200 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("flush_count", W'(c0), W'(0));
        chk("flush_empty", W'(e0), W'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("clr_set_wins", W'(un0), W'(1));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_errs", W'({ov0, un0, ov1, un1}), '0);

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int k = 0; k < 800; k++) begin
            wp  = ((k / 100) % 2 == 0) ? 75 : 30;
            rp  = 100 - wp;
            rnd = {$urandom(), $urandom(), $urandom()};
            pkt = rnd[W-1:0];
            cyc(($urandom_range(99) < wp), pkt, ($urandom_range(99) < rp),
                ($urandom_range(63) == 0), ($urandom_range(31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
